// File: rtl/symbol_slicer.sv
// Integrate-and-dump slicer recovering UART-style framed bytes (idle low, start high, 8 data LSB-first, stop low).
// Outputs register one cycle after the closing strobe; no backpressure, state only advances on sample_valid.
module symbol_slicer #(
  parameter int                 SPB    = 8,
  parameter logic signed [23:0] THRESH = 24'sd0
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic signed [23:0] sample_in,
  output logic               bit_out,
  output logic               bit_valid,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  output logic               frame_err,
  output logic               busy
);

  localparam int SW    = $clog2(SPB);
  localparam int ACC_W = 24 + SW + 1;

  localparam logic [SW-1:0] SCNT_LAST = SW'(SPB - 1);
  localparam logic [SW-1:0] SCNT_HALF = SW'(SPB / 2);
  // SPB is a power of two, so THRESH*SPB is an exact arithmetic shift
  localparam logic signed [ACC_W-1:0] THR_ACC = ACC_W'(THRESH) <<< SW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                    state_q, state_d;
  logic [SW-1:0]             scnt_q, scnt_d;
  logic [2:0]                bcnt_q, bcnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]                shreg_q, shreg_d;
  logic                      bit_q, bit_d;
  logic                      bit_vld_q, bit_vld_d;
  logic [7:0]                byte_q, byte_d;
  logic                      byte_vld_q, byte_vld_d;
  logic                      ferr_q, ferr_d;

  logic signed [ACC_W-1:0]   sum;
  logic                      win_last;
  logic                      bit_dec;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      scnt_q     <= '0;
      bcnt_q     <= '0;
      acc_q      <= '0;
      shreg_q    <= '0;
      bit_q      <= 1'b0;
      bit_vld_q  <= 1'b0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      bcnt_q     <= bcnt_d;
      acc_q      <= acc_d;
      shreg_q    <= shreg_d;
      bit_q      <= bit_d;
      bit_vld_q  <= bit_vld_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    sum      = acc_q + ACC_W'(sample_in);
    win_last = (scnt_q == SCNT_LAST);
    bit_dec  = (sum > THR_ACC);

    state_d    = state_q;
    scnt_d     = scnt_q;
    bcnt_d     = bcnt_q;
    acc_d      = acc_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    bit_vld_d  = 1'b0;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    ferr_d     = 1'b0;

    if (sample_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (sample_in > THRESH) begin
            state_d = S_START;
            scnt_d  = SW'(1);
          end
        end

        S_START: begin
          // Mid-start recheck rejects single-sample glitches; it wins over window end when SPB==2
          if ((scnt_q == SCNT_HALF) && (sample_in <= THRESH)) begin
            state_d = S_IDLE;
            scnt_d  = '0;
          end else if (win_last) begin
            state_d = S_DATA;
            scnt_d  = '0;
            acc_d   = '0;
            bcnt_d  = '0;
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end

        S_DATA: begin
          if (win_last) begin
            shreg_d   = {bit_dec, shreg_q[7:1]};
            bit_d     = bit_dec;
            bit_vld_d = 1'b1;
            acc_d     = '0;
            scnt_d    = '0;
            if (bcnt_q == 3'd7) begin
              state_d = S_STOP;
              bcnt_d  = '0;
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end else begin
            acc_d  = sum;
            scnt_d = scnt_q + SW'(1);
          end
        end

        S_STOP: begin
          if (win_last) begin
            if (!bit_dec) begin
              byte_d     = shreg_q;
              byte_vld_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
            state_d = S_IDLE;
            acc_d   = '0;
            scnt_d  = '0;
          end else begin
            acc_d  = sum;
            scnt_d = scnt_q + SW'(1);
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bit_out    = bit_q;
  assign bit_valid  = bit_vld_q;
  assign byte_out   = byte_q;
  assign byte_valid = byte_vld_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);

endmodule
